schmidl_cox_frame_ctrl: RTL
===========================

Name: schmidl_cox_frame_ctrl

Overview:
Frame-synchronisation controller placed after the Schmidl-Cox metric calculator. It takes the sample stream and the sample-aligned M(d) metric stream. It detects a threshold crossing and tracks the metric peak over a search window. It then skips to the configured frame start and forwards exactly one frame of samples downstream with tlast on the last sample, then re-arms.

Parameters:
SAMPLE_WIDTH, 32, sample width ([I,Q], I in upper half)
METRIC_WIDTH, 32, unsigned metric width
CNT_WIDTH, 16, width of all length/offset counters and config fields

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort: return to SEARCH, counters zeroed
enable  in  1  detection enable, sampled in SEARCH only
threshold  in  METRIC_WIDTH  detection threshold (strict >)
window_len  in  CNT_WIDTH  peak search window in beats (0 treated as 1)
frame_offset  in  CNT_WIDTH  frame start distance from peak, in beats
frame_len  in  CNT_WIDTH  samples per frame (0 treated as 1)
s_tdata  in  SAMPLE_WIDTH  sample stream data
s_tvalid  in  1  sample valid
s_tready  out  1  sample ready
m_tdata  in  METRIC_WIDTH  metric stream, beat-aligned with samples
m_tvalid  in  1  metric valid
m_tready  out  1  metric ready
o_tdata  out  SAMPLE_WIDTH  frame samples
o_tlast  out  1  last sample of frame
o_tvalid  out  1  output valid
o_tready  in  1  output ready
det_pulse  out  1  one-cycle pulse when the window closes
late  out  1  sticky per frame: requested start already passed
peak_metric  out  METRIC_WIDTH  peak value of the last detection
frame_cnt  out  CNT_WIDTH  completed frames, wraps

Behaviour:
- Reset (reset_n=0, async) values: state SEARCH; all outputs 0; all counters 0.
- Joint beat: a beat fires when s_tvalid & m_tvalid & (state!=STREAM | o_tready).
- s_tready = m_tready = s_tvalid & m_tvalid & (state!=STREAM | o_tready). The two inputs are always consumed together.
- Input tlast is ignored.
- SEARCH: every beat is dropped.
  - If enable & m_tdata>threshold, the beat becomes index 0.
  - Latch window_len, frame_offset and frame_len.
  - peak=m_tdata, since_peak=0, win_cnt=1. Go to PEAK. If latched W=1, close the window immediately (see below).
- PEAK: every beat is dropped and win_cnt increments.
  - If m_tdata>peak (strict; first maximum wins): peak=m_tdata, since_peak=0. Otherwise since_peak increments.
- Window close (win_cnt==W after the beat):
  - det_pulse=1 for one cycle; peak_metric=peak.
  - Peak index p = W-1-since_peak. skip = p+frame_offset-W.
  - If skip>0, go to SKIP with skip_cnt=skip.
  - If p+frame_offset==W, go to STREAM.
  - If p+frame_offset<W, set late=1 and go to STREAM (the frame starts at beat W).
  - Arithmetic uses CNT_WIDTH+1 bits, signed compare.
- SKIP: every beat is dropped and skip_cnt decrements. Go to STREAM on the beat that makes it 0.
- STREAM: combinational pass-through.
  - o_tdata=s_tdata; o_tvalid=s_tvalid&m_tvalid; the metric is discarded.
  - out_cnt increments per beat. o_tlast=(out_cnt==frame_len-1).
  - On the tlast beat: frame_cnt+1, late cleared, go to SEARCH. The next beat is eligible for detection.
- o_tvalid=0 in every state except STREAM.
- Config changes outside SEARCH have no effect until the next detection.
- clear has priority over beat logic in the same cycle.
  - Mid-STREAM clear aborts the frame: no tlast, frame_cnt unchanged.
  - peak_metric is held.
- Latency: 0 cycles sample-to-output in STREAM; det_pulse in the cycle after the window-closing beat.
- No combinational path from o_tready to o_tvalid.

Decomposition:
- Package schmidl_cox_pkg holds:
  - state enum (SEARCH, PEAK, SKIP, STREAM);
  - CNT_WIDTH default;
  - the "0 treated as 1" length-sanitise function.
- One sub-module, sc_peak_tracker, holds the running max, since_peak and win_cnt, with start/beat/done interface.
- The top-level FSM and counters stay in schmidl_cox_frame_ctrl.

Test Plan:
1. Basic frame detection:
   - Setup: threshold=1000, W=4, offset=8, frame_len=6; metric 0,0,1200,1500,1800,1100,0…; sample data=beat index, o_tready=1.
   - Required: det_pulse once, peak_metric=1800, skip=6, output samples 12..17, tlast on 17, frame_cnt=1, late=0.
2. Tie and boundary:
   - Stimulus: window metric 1500,1500,900,900 with W=4, offset=5.
   - Required: peak index 0, frame starts at beat 5. A metric equal to threshold (1000) never triggers.
3. Backpressure:
   - Stimulus: random o_tready and random s_tvalid/m_tvalid.
   - Required: output sequence identical to scenario 1, no duplicates or drops, s_tready low whenever o_tready is low in STREAM.
4. Late start and minimum window:
   - Stimulus: W=8, offset=2, peak at window index 1.
   - Required: late=1, frame starts at beat 8. With W=0, behaves as W=1.
5. Abort and re-arm:
   - Stimulus: clear after 3 STREAM beats, then a new crossing.
   - Required: no tlast, frame_cnt unchanged, fresh detection produces a full frame.
6. Asynchronous reset:
   - Stimulus: reset_n pulsed low mid-SKIP between clock edges.
   - Required: all outputs 0 immediately, SEARCH after release, enable=0 suppresses detection.

Source files
------------

// File: rtl/schmidl_cox_frame_ctrl_pkg.sv
// Shared types and helpers for the Schmidl-Cox frame-synchronisation controller.
package schmidl_cox_pkg;

  localparam int CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    PEAK   = 2'd1,
    SKIP   = 2'd2,
    STREAM = 2'd3
  } state_e;

  // A zero-length window or frame would never terminate, so it is read as one beat.
  function automatic int unsigned len_sanitise(input int unsigned len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/schmidl_cox_frame_ctrl_if.sv
// Joint sample/metric input streams plus the framed sample output stream.
interface schmidl_cox_frame_ctrl_if #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int METRIC_WIDTH = 32
) ();

  logic [SAMPLE_WIDTH-1:0] s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic [METRIC_WIDTH-1:0] m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic [SAMPLE_WIDTH-1:0] o_tdata;
  logic                    o_tlast;
  logic                    o_tvalid;
  logic                    o_tready;

  modport master (
    output s_tdata, s_tvalid, m_tdata, m_tvalid, o_tready,
    input  s_tready, m_tready, o_tdata, o_tlast, o_tvalid
  );

  modport slave (
    input  s_tdata, s_tvalid, m_tdata, m_tvalid, o_tready,
    output s_tready, m_tready, o_tdata, o_tlast, o_tvalid
  );

endinterface

// File: rtl/schmidl_cox_frame_ctrl_peak_tracker.sv
// Running maximum over the detection window: peak value, beats since the peak, window fill.
module sc_peak_tracker #(
  parameter int METRIC_WIDTH = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic                    i_start,
  input  logic                    i_beat,
  input  logic [METRIC_WIDTH-1:0] i_metric,
  input  logic [CNT_WIDTH-1:0]    i_win_len,
  output logic                    o_done,
  output logic [METRIC_WIDTH-1:0] o_peak,
  output logic [CNT_WIDTH-1:0]    o_since
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  logic [METRIC_WIDTH-1:0] r_peak;
  logic [METRIC_WIDTH-1:0] w_peak_nxt;
  logic [CNT_WIDTH-1:0]    r_since;
  logic [CNT_WIDTH-1:0]    w_since_nxt;
  logic [CNT_WIDTH-1:0]    r_win_cnt;
  logic [CNT_WIDTH-1:0]    w_win_cnt_nxt;
  logic                    w_upd;

  assign w_upd = i_start | i_beat;

  // Strict compare keeps the first occurrence of a repeated maximum.
  always_comb begin
    w_peak_nxt    = r_peak;
    w_since_nxt   = r_since;
    w_win_cnt_nxt = r_win_cnt;
    if (i_start) begin
      w_peak_nxt    = i_metric;
      w_since_nxt   = '0;
      w_win_cnt_nxt = C_ONE;
    end else if (i_beat) begin
      w_win_cnt_nxt = r_win_cnt + C_ONE;
      if (i_metric > r_peak) begin
        w_peak_nxt  = i_metric;
        w_since_nxt = '0;
      end else begin
        w_since_nxt = r_since + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak    <= '0;
      r_since   <= '0;
      r_win_cnt <= '0;
    end else if (i_clear) begin
      r_peak    <= '0;
      r_since   <= '0;
      r_win_cnt <= '0;
    end else if (w_upd) begin
      r_peak    <= w_peak_nxt;
      r_since   <= w_since_nxt;
      r_win_cnt <= w_win_cnt_nxt;
    end
  end

  assign o_done  = w_upd & (w_win_cnt_nxt == i_win_len);
  assign o_peak  = w_peak_nxt;
  assign o_since = w_since_nxt;

endmodule

// File: rtl/schmidl_cox_frame_ctrl.sv
// Frame-sync controller: threshold detect, windowed peak search, skip to frame start,
// forward one frame with tlast, then re-arm.
module schmidl_cox_frame_ctrl
  import schmidl_cox_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32,
  parameter int METRIC_WIDTH = 32,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [METRIC_WIDTH-1:0] threshold,
  input  logic [CNT_WIDTH-1:0]    window_len,
  input  logic [CNT_WIDTH-1:0]    frame_offset,
  input  logic [CNT_WIDTH-1:0]    frame_len,
  schmidl_cox_frame_ctrl_if.slave bus,
  output logic                    det_pulse,
  output logic                    late,
  output logic [METRIC_WIDTH-1:0] peak_metric,
  output logic [CNT_WIDTH-1:0]    frame_cnt
);

  localparam logic [CNT_WIDTH-1:0]      C_ONE    = CNT_WIDTH'(1);
  localparam logic signed [CNT_WIDTH:0] C_S_ONE  = (CNT_WIDTH+1)'(1);
  localparam logic signed [CNT_WIDTH:0] C_S_ZERO = '0;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [CNT_WIDTH-1:0]     r_win_len;
  logic [CNT_WIDTH-1:0]     r_offset;
  logic [CNT_WIDTH-1:0]     r_frame_len;
  logic [CNT_WIDTH-1:0]     r_skip_cnt;
  logic [CNT_WIDTH-1:0]     r_out_cnt;
  logic [CNT_WIDTH-1:0]     r_frame_cnt;
  logic                     r_late;
  logic                     r_det_pulse;
  logic [METRIC_WIDTH-1:0]  r_peak_metric;

  logic                     w_beat;
  logic                     w_active;
  logic                     w_detect;
  logic                     w_track_beat;
  logic                     w_last;
  logic [CNT_WIDTH-1:0]     w_win_len;
  logic [CNT_WIDTH-1:0]     w_offset_eff;
  logic [CNT_WIDTH-1:0]     w_frame_len_in;
  logic                     w_done;
  logic [METRIC_WIDTH-1:0]  w_peak;
  logic [CNT_WIDTH-1:0]     w_since;
  logic signed [CNT_WIDTH:0] w_p;
  logic signed [CNT_WIDTH:0] w_skip;
  state_e                   w_close_state;
  logic [SAMPLE_WIDTH-1:0]  w_tdata;

  // Sample and metric are always consumed together; ready is held low during reset.
  assign w_beat   = reset_n & bus.s_tvalid & bus.m_tvalid &
                    ((r_state != STREAM) | bus.o_tready);
  assign w_active = w_beat & ~clear;

  assign bus.s_tready = w_beat;
  assign bus.m_tready = w_beat;

  assign w_win_len      = (r_state == SEARCH) ? CNT_WIDTH'(len_sanitise(32'(window_len))) : r_win_len;
  assign w_offset_eff   = (r_state == SEARCH) ? frame_offset : r_offset;
  assign w_frame_len_in = CNT_WIDTH'(len_sanitise(32'(frame_len)));

  assign w_detect     = w_active & (r_state == SEARCH) & enable & (bus.m_tdata > threshold);
  assign w_track_beat = w_active & (r_state == PEAK);

  sc_peak_tracker #(
    .METRIC_WIDTH (METRIC_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_peak (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (clear),
    .i_start   (w_detect),
    .i_beat    (w_track_beat),
    .i_metric  (bus.m_tdata),
    .i_win_len (w_win_len),
    .o_done    (w_done),
    .o_peak    (w_peak),
    .o_since   (w_since)
  );

  // Frame start relative to the window end; negative means the start already went by.
  assign w_p    = $signed({1'b0, w_win_len}) - C_S_ONE - $signed({1'b0, w_since});
  assign w_skip = w_p + $signed({1'b0, w_offset_eff}) - $signed({1'b0, w_win_len});
  assign w_close_state = (w_skip > C_S_ZERO) ? SKIP : STREAM;

  assign w_last = (r_out_cnt == (r_frame_len - C_ONE));

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = SEARCH;
    end else begin
      unique case (r_state)
        SEARCH: if (w_detect) w_state_nxt = w_done ? w_close_state : PEAK;
        PEAK:   if (w_done) w_state_nxt = w_close_state;
        SKIP:   if (w_active && (r_skip_cnt == C_ONE)) w_state_nxt = STREAM;
        STREAM: if (w_active && w_last) w_state_nxt = SEARCH;
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= SEARCH;
      r_win_len     <= '0;
      r_offset      <= '0;
      r_frame_len   <= '0;
      r_skip_cnt    <= '0;
      r_out_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_late        <= 1'b0;
      r_det_pulse   <= 1'b0;
      r_peak_metric <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_det_pulse <= w_done;
      if (clear) begin
        r_skip_cnt <= '0;
        r_out_cnt  <= '0;
        r_late     <= 1'b0;
      end else begin
        if (w_detect) begin
          r_win_len   <= w_win_len;
          r_offset    <= frame_offset;
          r_frame_len <= w_frame_len_in;
        end
        if (w_done) begin
          r_peak_metric <= w_peak;
          r_late        <= (w_skip < C_S_ZERO);
          r_out_cnt     <= '0;
          r_skip_cnt    <= (w_skip > C_S_ZERO) ? w_skip[CNT_WIDTH-1:0] : '0;
        end
        if (w_active && (r_state == SKIP)) begin
          r_skip_cnt <= r_skip_cnt - C_ONE;
        end
        if (w_active && (r_state == STREAM)) begin
          if (w_last) begin
            r_out_cnt   <= '0;
            r_frame_cnt <= r_frame_cnt + C_ONE;
            r_late      <= 1'b0;
          end else begin
            r_out_cnt <= r_out_cnt + C_ONE;
          end
        end
      end
    end
  end

  // Output side is a pure pass-through while streaming; o_tready never reaches o_tvalid.
  assign w_tdata      = (r_state == STREAM) ? bus.s_tdata : '0;
  assign bus.o_tdata  = w_tdata;
  assign bus.o_tvalid = (r_state == STREAM) & bus.s_tvalid & bus.m_tvalid;
  assign bus.o_tlast  = (r_state == STREAM) & w_last;

  assign det_pulse   = r_det_pulse;
  assign late        = r_late;
  assign peak_metric = r_peak_metric;
  assign frame_cnt   = r_frame_cnt;

endmodule
